// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU/MDU completions into one registered RF write port.
// Latency 1 cycle transfer->rf_wen; readies are combinational from valids and starvation counters.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  byp_raddr1,
  input  logic [4:0]  byp_raddr2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  lsu_cnt, mdu_cnt;
  logic        lsu_starved, mdu_starved;
  logic        xfer;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  function automatic logic [3:0] next_cnt(input logic valid, input logic granted,
                                          input logic [3:0] cnt);
    if (!valid || granted) return 4'd0;
    if (cnt == LIMIT)      return LIMIT;
    return cnt + 4'd1;
  endfunction

  // Starved requesters pre-empt the ALU; MDU outranks LSU when both are starved.
  always_comb begin
    alu_ready   = 1'b0;
    lsu_ready   = 1'b0;
    mdu_ready   = 1'b0;
    mdu_starved = mdu_valid && (mdu_cnt == LIMIT);
    lsu_starved = lsu_valid && (lsu_cnt == LIMIT);
    if (!rst) begin
      if (mdu_starved)      mdu_ready = 1'b1;
      else if (lsu_starved) lsu_ready = 1'b1;
      else if (alu_valid)   alu_ready = 1'b1;
      else if (lsu_valid)   lsu_ready = 1'b1;
      else if (mdu_valid)   mdu_ready = 1'b1;
    end
  end

  always_comb begin
    xfer     = alu_ready | lsu_ready | mdu_ready;
    win_rd   = 5'd0;
    win_data = 32'd0;
    if (alu_ready) begin
      win_rd   = alu_rd;
      win_data = alu_data;
    end else if (lsu_ready) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end else if (mdu_ready) begin
      win_rd   = mdu_rd;
      win_data = mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_cnt <= 4'd0;
      mdu_cnt <= 4'd0;
    end else begin
      lsu_cnt <= next_cnt(lsu_valid, lsu_ready, lsu_cnt);
      mdu_cnt <= next_cnt(mdu_valid, mdu_ready, mdu_cnt);
    end
  end

  // x0 writes are accepted but leave address/data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_wen <= xfer && (win_rd != 5'd0);
      if (xfer && (win_rd != 5'd0)) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  assign byp_hit1  = rf_wen && (byp_raddr1 == rf_waddr) && (byp_raddr1 != 5'd0);
  assign byp_hit2  = rf_wen && (byp_raddr2 == rf_waddr) && (byp_raddr2 != 5'd0);
  assign byp_data1 = byp_hit1 ? rf_wdata : 32'd0;
  assign byp_data2 = byp_hit2 ? rf_wdata : 32'd0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected RF writes are queued when stimulus is driven
// and popped one cycle later against rf_wen/rf_waddr/rf_wdata.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  byp_raddr1, byp_raddr2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check readies against the expected grant, queue the resulting write,
  // clock, then compare the registered port against the queued entry.
  task automatic step(input logic ea, input logic el, input logic em);
    exp_t e;
    #1;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
    chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, el});
    chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, em});
    e = '{wen: 1'b0, addr: last_addr, data: last_data};
    if (rst)                     e = '{wen: 1'b0, addr: 5'd0, data: 32'd0};
    else if (ea && alu_rd != 0)  e = '{wen: 1'b1, addr: alu_rd, data: alu_data};
    else if (el && lsu_rd != 0)  e = '{wen: 1'b1, addr: lsu_rd, data: lsu_data};
    else if (em && mdu_rd != 0)  e = '{wen: 1'b1, addr: mdu_rd, data: mdu_data};
    sb.push_back(e);
    last_addr = e.addr;
    last_data = e.data;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rf_wen",   {31'd0, rf_wen},   {31'd0, e.wen});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
    chk("rf_wdata", rf_wdata,          e.data);
  endtask

  task automatic chk_byp(input logic h1, input logic [31:0] d1,
                         input logic h2, input logic [31:0] d2);
    #1;
    chk("byp_hit1",  {31'd0, byp_hit1}, {31'd0, h1});
    chk("byp_data1", byp_data1, d1);
    chk("byp_hit2",  {31'd0, byp_hit2}, {31'd0, h2});
    chk("byp_data2", byp_data2, d2);
  endtask

  initial begin
    last_addr = 5'd0;
    last_data = 32'd0;
    // Reset with every requester asserting valid
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h33;
    byp_raddr1 = 5'd1; byp_raddr2 = 5'd0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_byp(0, 32'd0, 0, 32'd0);

    // Single ALU write, bypass hit on port 1 only
    rst = 1'b0;
    lsu_valid = 1'b0; mdu_valid = 1'b0;
    alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step(1, 0, 0);
    alu_valid = 1'b0;
    byp_raddr1 = 5'd5; byp_raddr2 = 5'd6;
    chk_byp(1, 32'hDEADBEEF, 0, 32'd0);
    step(0, 0, 0);
    chk_byp(0, 32'd0, 0, 32'd0);

    // x0 load is accepted and discarded
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    step(0, 1, 0);
    lsu_valid = 1'b0;
    byp_raddr1 = 5'd0;
    chk_byp(0, 32'd0, 0, 32'd0);

    // Fixed priority, back-to-back grants
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2B2B2;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hC3C3C3C3;
    byp_raddr1 = 5'd1; byp_raddr2 = 5'd2;
    step(1, 0, 0);
    alu_valid = 1'b0;
    chk_byp(1, 32'hA1A1A1A1, 0, 32'd0);
    step(0, 1, 0);
    lsu_valid = 1'b0;
    chk_byp(0, 32'd0, 1, 32'hB2B2B2B2);
    step(0, 0, 1);
    mdu_valid = 1'b0;
    step(0, 0, 0);

    // MDU starvation against a continuous ALU stream, then the counter restarts
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h9;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hAAAA0010;
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 1);
    mdu_valid = 1'b0;
    step(1, 0, 0);

    // Both LSU and MDU starved: MDU first, then LSU, then ALU resumes
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hBBBB0011;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hCCCC0012;
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 1);
    mdu_valid = 1'b0;
    step(0, 1, 0);
    lsu_valid = 1'b0;
    step(1, 0, 0);
    alu_valid = 1'b0;
    step(0, 0, 0);

    // Reset drops the write sitting in the output register
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h55;
    byp_raddr1 = 5'd7;
    step(1, 0, 0);
    alu_valid = 1'b0;
    chk_byp(1, 32'h55, 0, 32'd0);
    rst = 1'b1;
    step(0, 0, 0);
    chk_byp(0, 32'd0, 0, 32'd0);
    rst = 1'b0;
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
